// File: rtl/mem_stage_lsu_if.sv
// Data-bus interface between the memory-stage LSU and data memory.
// The LSU is the master: it drives the request fields and receives ready and read data.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns an M-stage load/store into a req/ready
// bus transaction with byte enables, stalls the pipeline until the bus
// completes, and aligns/extends the returned load data for the DONE cycle.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWriteM,
    input  logic                   MemReadM,
    input  logic [2:0]             Funct3M,
    input  logic [31:0]            ALUResultM,
    input  logic [31:0]            WriteDataM,
    output logic [31:0]            ReadDataM,
    output logic                   StallM,
    output logic                   MisalignM,
    output logic                   BusErrM,
    mem_stage_lsu_if.master        dmem
);

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_req;
    logic            r_we;
    logic [31:0]     r_addr;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_access;
    logic            w_misal;
    logic            w_go;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_sh_b;
    logic [31:0]     w_sh_h;

    // Decode access size, alignment and store lane placement from the M-stage inputs.
    always_comb begin
        w_access = MemReadM | MemWriteM;
        w_misal  = 1'b0;
        w_be     = 4'b1111;
        w_wdata  = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_misal = ALUResultM[0];
                w_be    = 4'b0011 << {ALUResultM[1], 1'b0};
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_misal = |ALUResultM[1:0];
            end
        endcase
        MisalignM = w_access & w_misal;
        w_go      = w_access & ~w_misal;
    end

    // Stall while a request is being issued or outstanding; release in DONE so the pipeline advances.
    always_comb begin
        StallM = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_go);
    end

    // Extract and extend load data from the captured word; zero outside DONE, on stores and on bus error.
    always_comb begin
        w_sh_b    = r_rdata >> {r_off, 3'b000};
        w_sh_h    = r_rdata >> {r_off[1], 4'b0000};
        ReadDataM = '0;
        if ((r_state == S_DONE) && !r_we && !r_err) begin
            case (r_f3)
                3'b000:  ReadDataM = {{24{w_sh_b[7]}}, w_sh_b[7:0]};
                3'b001:  ReadDataM = {{16{w_sh_h[15]}}, w_sh_h[15:0]};
                3'b100:  ReadDataM = {24'h000000, w_sh_b[7:0]};
                3'b101:  ReadDataM = {16'h0000, w_sh_h[15:0]};
                default: ReadDataM = r_rdata;
            endcase
        end
    end

    // Transaction FSM: latch the request in IDLE, wait for ready or timeout in BUSY, present results in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (w_go) begin
                        r_req   <= 1'b1;
                        r_we    <= MemWriteM;
                        r_addr  <= {ALUResultM[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_f3    <= Funct3M;
                        r_off   <= ALUResultM[1:0];
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dmem.dmem_ready) begin
                        r_rdata <= dmem.dmem_rdata;
                        r_req   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rdata <= '0;
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign BusErrM         = r_err & (r_state == S_DONE);

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expected values.
module tb_mem_stage_lsu;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic        MemReadM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;

    int n_checks;
    int n_pass;

    mem_stage_lsu_if dmem_bus ();

    mem_stage_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .dmem       (dmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one access; the bus answers with ready on the lat-th request cycle (lat=0: never).
    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int lat,
                           output logic [31:0] rdm, output int stalls, output int reqcyc,
                           output logic [3:0] be, output logic [31:0] wdata,
                           output logic [31:0] addr, output logic err, output logic we);
        bit done;
        @(posedge clk); #1;
        MemWriteM  = wr;
        MemReadM   = ~wr;
        Funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = rd;
        stalls = 0; reqcyc = 0; done = 0;
        rdm = '0; be = '0; wdata = '0; addr = '0; err = 1'b0; we = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (StallM) stalls++;
            if (dmem_bus.dmem_req) begin
                reqcyc++;
                be    = dmem_bus.dmem_be;
                wdata = dmem_bus.dmem_wdata;
                addr  = dmem_bus.dmem_addr;
                we    = dmem_bus.dmem_we;
                dmem_bus.dmem_ready = (reqcyc == lat);
            end else if (!StallM && reqcyc > 0) begin
                rdm  = ReadDataM;
                err  = BusErrM;
                done = 1;
                dmem_bus.dmem_ready = 1'b0;
                MemWriteM = 1'b0;
                MemReadM  = 1'b0;
            end
        end
        if (!done) begin
            check("txn_timeout", 32'd0, 32'd1);
            MemWriteM = 1'b0;
            MemReadM  = 1'b0;
            dmem_bus.dmem_ready = 1'b0;
        end
    endtask

    logic [31:0] rdm, wdata, addr;
    logic [3:0]  be;
    logic        err, we;
    int          stalls, reqcyc;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0;
        MemWriteM = 1'b0; MemReadM = 1'b0; Funct3M = 3'b000;
        ALUResultM = '0; WriteDataM = '0;
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rst_addr",  dmem_bus.dmem_addr, 32'd0);
        check("rst_be",    {28'd0, dmem_bus.dmem_be}, 32'd0);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        check("rst_rd",    ReadDataM, 32'd0);
        check("rst_err",   {31'd0, BusErrM}, 32'd0);
        reset = 1'b1;

        // Ready while idle with no access is ignored
        @(negedge clk);
        dmem_bus.dmem_ready = 1'b1;
        @(negedge clk);
        check("idle_ready_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("idle_ready_stall", {31'd0, StallM}, 32'd0);
        check("idle_ready_rd",    ReadDataM, 32'd0);
        dmem_bus.dmem_ready = 1'b0;

        // LW 0x100
        run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("lw_stalls", stalls, 32'd2);
        check("lw_rd",     rdm, 32'hDEADBEEF);
        check("lw_be",     {28'd0, be}, 32'hF);
        check("lw_addr",   addr, 32'h100);
        check("lw_we",     {31'd0, we}, 32'd0);
        check("lw_err",    {31'd0, err}, 32'd0);

        // LB / LBU / LH / LHU
        run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("lb_rd", rdm, 32'hFFFFFF80);
        check("lb_be", {28'd0, be}, 32'h8);
        run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("lbu_rd", rdm, 32'h00000080);
        run_txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("lhu_rd", rdm, 32'h00008011);
        run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("lh_rd", rdm, 32'hFFFF8011);
        run_txn(1'b0, 3'b000, 32'h101, 32'h0, 32'h80112233, 3, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("lb1_rd",     rdm, 32'h00000022);
        check("lb1_stalls", stalls, 32'd4);

        // SB / SH / SW
        run_txn(1'b1, 3'b000, 32'h6, 32'h000000A5, 32'h12345678, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("sb_be",    {28'd0, be}, 32'h4);
        check("sb_wdata", wdata, 32'hA5A5A5A5);
        check("sb_addr",  addr, 32'h4);
        check("sb_we",    {31'd0, we}, 32'd1);
        check("sb_rd",    rdm, 32'd0);
        run_txn(1'b1, 3'b001, 32'h6, 32'h000000A5, 32'h0, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("sh_be",    {28'd0, be}, 32'hC);
        check("sh_wdata", wdata, 32'h00A500A5);
        run_txn(1'b1, 3'b010, 32'h208, 32'hCAFEF00D, 32'h0, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("sw_be",    {28'd0, be}, 32'hF);
        check("sw_wdata", wdata, 32'hCAFEF00D);
        check("sw_addr",  addr, 32'h208);

        // Misaligned LW 0x102 and SH 0x1
        @(posedge clk); #1;
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUResultM = 32'h102;
        @(negedge clk);
        check("mis_lw_flag",  {31'd0, MisalignM}, 32'd1);
        check("mis_lw_stall", {31'd0, StallM}, 32'd0);
        check("mis_lw_rd",    ReadDataM, 32'd0);
        @(negedge clk);
        check("mis_lw_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        MemReadM = 1'b0; MemWriteM = 1'b1; Funct3M = 3'b001; ALUResultM = 32'h1;
        @(negedge clk);
        check("mis_sh_flag",  {31'd0, MisalignM}, 32'd1);
        check("mis_sh_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        MemWriteM = 1'b0;
        #1;
        check("mis_noacc",    {31'd0, MisalignM}, 32'd0);

        // Timeout: ready never arrives
        run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h55555555, 0, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("to_reqcyc", reqcyc, 32'd4);
        check("to_err",    {31'd0, err}, 32'd1);
        check("to_rd",     rdm, 32'd0);
        @(negedge clk);
        check("to_err_clr", {31'd0, BusErrM}, 32'd0);

        // Reset asserted in BUSY
        @(posedge clk); #1;
        MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400;
        @(negedge clk);
        @(negedge clk);
        check("rb_req_busy", {31'd0, dmem_bus.dmem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("rb_req_drop", {31'd0, dmem_bus.dmem_req}, 32'd0);
        MemReadM = 1'b0;
        dmem_bus.dmem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rb_req_after",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        check("rb_stall_after", {31'd0, StallM}, 32'd0);
        check("rb_rd_after",    ReadDataM, 32'd0);
        check("rb_err_after",   {31'd0, BusErrM}, 32'd0);
        dmem_bus.dmem_ready = 1'b0;

        // Recovery after reset
        run_txn(1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 1, rdm, stalls, reqcyc, be, wdata, addr, err, we);
        check("post_rst_rd", rdm, 32'h0BADF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
